// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared constants for the multi-cycle MIPS controller:
//                opcode/funct values, FSM state encoding, ALU operation
//                codes, memory access size codes and the decode bundle
//                passed from the classifier to the FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;   // bltz / bgez, selected by rt[16]
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_MUL    = 6'b011100;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function field (instr[5:0])
    localparam logic [5:0] FN_JR     = 6'b001000;

    // FSM states; the numeric values are visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MULW   = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALU_R   = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_GTZ = 4'b0111;
    localparam logic [3:0] ALU_LEZ = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1011;

    // Memory access size codes
    localparam logic [1:0] MSZ_NONE = 2'b00;
    localparam logic [1:0] MSZ_BYTE = 2'b01;
    localparam logic [1:0] MSZ_HALF = 2'b10;
    localparam logic [1:0] MSZ_WORD = 2'b11;

    // Classification of one instruction
    typedef struct packed {
        logic       alu;       // register/immediate ALU op (EXEC -> WB)
        logic       load;
        logic       store;
        logic       branch;
        logic       br_taken;
        logic       jump;      // j or jal
        logic       jal;
        logic       jr;
        logic       mul;
        logic       bad;       // undefined opcode
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] msize;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
// ============================================================================
//  Module      : mips_ctrl_decode
//  Description : Purely combinational opcode classifier. Turns the opcode,
//                funct and rt[16] fields plus the register-compare flags
//                into a dec_t bundle consumed by the controller FSM.
//  Ports       : opcode_i, funct_i, rt16_i  - instruction fields
//                rsgz_i, rsez_i, tes_i      - rs>0, rs==0, rs==rt
//                dec_o                      - classification bundle
//  Config      : MIPS_MC_MUL_EN - when defined, opcode 011100 decodes as
//                mul; otherwise it is treated as undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       rt16_i,
    input  logic       rsgz_i,
    input  logic       rsez_i,
    input  logic       tes_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_JR) begin
                    dec_o.jr = 1'b1;
                end else begin
                    dec_o.alu     = 1'b1;
                    dec_o.reg_dst = 1'b1;
                    dec_o.alu_op  = ALU_R;
                end
            end
            OP_REGIMM: begin
                dec_o.branch   = 1'b1;
                // rt[16]=1 is bgez (rs>=0), rt[16]=0 is bltz (rs<0)
                dec_o.br_taken = rt16_i ? (rsez_i | rsgz_i) : (~rsez_i & ~rsgz_i);
            end
            OP_BEQ: begin
                dec_o.branch   = 1'b1;
                dec_o.br_taken = tes_i;
            end
            OP_BNE: begin
                dec_o.branch   = 1'b1;
                dec_o.br_taken = ~tes_i;
            end
            OP_BLEZ: begin
                dec_o.branch   = 1'b1;
                dec_o.br_taken = rsez_i | ~rsgz_i;
                dec_o.alu_op   = ALU_LEZ;
            end
            OP_BGTZ: begin
                dec_o.branch   = 1'b1;
                dec_o.br_taken = rsgz_i & ~rsez_i;
                dec_o.alu_op   = ALU_GTZ;
            end
            OP_J: begin
                dec_o.jump = 1'b1;
            end
            OP_JAL: begin
                dec_o.jump = 1'b1;
                dec_o.jal  = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_o.alu     = 1'b1;
                dec_o.alu_src = 1'b1;
                case (opcode_i)
                    OP_ADDI: dec_o.alu_op = ALU_ADD;
                    OP_SLTI: dec_o.alu_op = ALU_SLT;
                    OP_ANDI: dec_o.alu_op = ALU_AND;
                    OP_ORI:  dec_o.alu_op = ALU_OR;
                    default: dec_o.alu_op = ALU_XOR;
                endcase
            end
            OP_LB, OP_LH, OP_LW: begin
                dec_o.load    = 1'b1;
                dec_o.alu_src = 1'b1;
                dec_o.alu_op  = ALU_ADD;
                dec_o.msize   = (opcode_i == OP_LB) ? MSZ_BYTE :
                                (opcode_i == OP_LH) ? MSZ_HALF : MSZ_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_o.store   = 1'b1;
                dec_o.alu_src = 1'b1;
                dec_o.alu_op  = ALU_ADD;
                dec_o.msize   = (opcode_i == OP_SB) ? MSZ_BYTE :
                                (opcode_i == OP_SH) ? MSZ_HALF : MSZ_WORD;
            end
`ifdef MIPS_MC_MUL_EN
            OP_MUL: begin
                dec_o.mul     = 1'b1;
                dec_o.reg_dst = 1'b1;
                dec_o.alu_op  = ALU_MUL;
            end
`endif
            default: begin
                dec_o.bad = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// ============================================================================
//  Module      : mips_mc_controller
//  Description : Multi-cycle MIPS control unit. FSM walks FETCH, DECODE,
//                EXEC, MEM, WB (plus MULW for mul and a terminal TRAP for
//                undefined opcodes). Branches and jumps retire in DECODE.
//                Opcode/funct/rt[16] are captured while in DECODE; every
//                later state decodes from that copy.
//  Ports       : clk, rst_n (async, active-low)
//                instr, instr_valid           - fetch return
//                rsgz, rsez, tes              - compare flags, valid in DECODE
//                mem_ready                    - data memory completion
//                fetch_req, ir_we, pc_we, pc_src
//                reg_write, reg_dst, alu_src, mem_to_reg, link, alu_op
//                mem_read, mem_write          - access size codes
//                illegal                      - sticky undefined-opcode flag
//                state                        - debug view of FSM state
//  Config      : MIPS_MC_MUL_EN - enables mul decode, MULW state and counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int ALUOP_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    input  logic               rsgz,
    input  logic               rsez,
    input  logic               tes,
    input  logic               mem_ready,
    output logic               fetch_req,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               link,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         mem_read,
    output logic [1:0]         mem_write,
    output logic               illegal,
    output logic [2:0]         state
);

    state_e      state_q, state_d;
    // Low through reset and the first edge after it: keeps every output
    // (including fetch_req) quiet until the controller is actually running.
    logic        run_q;
    logic [5:0]  op_q;
    logic [5:0]  fn_q;
    logic        rt16_q;

    logic        w_in_decode;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_rt16;
    dec_t        w_dec;

    logic        unused_instr_bits;
    assign unused_instr_bits = ^{instr[25:17], instr[15:6]};

    // DECODE looks at the live instruction; afterwards the captured copy.
    assign w_in_decode = (state_q == ST_DECODE);
    assign w_opcode    = w_in_decode ? instr[31:26] : op_q;
    assign w_funct     = w_in_decode ? instr[5:0]   : fn_q;
    assign w_rt16      = w_in_decode ? instr[16]    : rt16_q;

    mips_ctrl_decode u_decode (
        .opcode_i (w_opcode),
        .funct_i  (w_funct),
        .rt16_i   (w_rt16),
        .rsgz_i   (rsgz),
        .rsez_i   (rsez),
        .tes_i    (tes),
        .dec_o    (w_dec)
    );

`ifdef MIPS_MC_MUL_EN
    localparam logic [3:0] c_CNT_INIT = 4'(MUL_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [3:0] unused_cnt_init;
    assign unused_cnt_init = 4'(MUL_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            rt16_q  <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (run_q && w_in_decode) begin
                op_q   <= instr[31:26];
                fn_q   <= instr[5:0];
                rt16_q <= instr[16];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_req  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        alu_op     = '0;
        mem_read   = MSZ_NONE;
        mem_write  = MSZ_NONE;
        illegal    = 1'b0;
`ifdef MIPS_MC_MUL_EN
        cnt_d      = cnt_q;
`endif
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    fetch_req = 1'b1;
                    if (instr_valid) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_op  = ALUOP_W'(w_dec.alu_op);
                    alu_src = w_dec.alu_src;
                    reg_dst = w_dec.reg_dst;
                    if (w_dec.branch) begin
                        pc_we   = 1'b1;
                        pc_src  = w_dec.br_taken ? 2'b01 : 2'b00;
                        state_d = ST_FETCH;
                    end else if (w_dec.jump) begin
                        pc_we     = 1'b1;
                        pc_src    = 2'b10;
                        reg_write = w_dec.jal;
                        link      = w_dec.jal;
                        state_d   = ST_FETCH;
                    end else if (w_dec.jr) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b11;
                        state_d = ST_FETCH;
                    end else if (w_dec.alu || w_dec.load || w_dec.store) begin
                        state_d = ST_EXEC;
`ifdef MIPS_MC_MUL_EN
                    end else if (w_dec.mul) begin
                        cnt_d   = c_CNT_INIT;
                        state_d = ST_MULW;
`endif
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    alu_op  = ALUOP_W'(w_dec.alu_op);
                    alu_src = w_dec.alu_src;
                    reg_dst = w_dec.reg_dst;
                    state_d = (w_dec.load || w_dec.store) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    alu_op    = ALUOP_W'(w_dec.alu_op);
                    alu_src   = w_dec.alu_src;
                    reg_dst   = w_dec.reg_dst;
                    mem_read  = w_dec.load  ? w_dec.msize : MSZ_NONE;
                    mem_write = w_dec.store ? w_dec.msize : MSZ_NONE;
                    if (mem_ready) begin
                        if (w_dec.store) begin
                            // Stores have no write-back; retire here.
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    alu_op     = ALUOP_W'(w_dec.alu_op);
                    alu_src    = w_dec.alu_src;
                    reg_dst    = w_dec.reg_dst;
                    reg_write  = 1'b1;
                    pc_we      = 1'b1;
                    mem_to_reg = w_dec.load;
                    state_d    = ST_FETCH;
                end
`ifdef MIPS_MC_MUL_EN
                ST_MULW: begin
                    alu_op  = ALUOP_W'(w_dec.alu_op);
                    alu_src = w_dec.alu_src;
                    reg_dst = w_dec.reg_dst;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_WB;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
`endif
                ST_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ============================================================================
//  Module      : tb_mips_mc_controller
//  Description : Self-checking bench for mips_mc_controller. Each
//                instruction is classified from the ISA rules into an
//                expected per-cycle trace of outputs, which is compared
//                against the DUT every cycle. Directed cases first, then
//                randomized instructions, wait states and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_controller;

    localparam int c_MUL = 3;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MULW   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    typedef enum int {K_R, K_JR, K_ALUI, K_LOAD, K_STORE, K_BR, K_J, K_JAL, K_MUL, K_BAD} kind_e;

    typedef struct packed {
        logic       fetch_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       link;
        logic [3:0] alu_op;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic       illegal;
        logic [2:0] state;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        rsgz = 1'b0, rsez = 1'b0, tes = 1'b0;
    logic        mem_ready = 1'b0;
    logic        fetch_req, ir_we, pc_we, reg_write, reg_dst, alu_src, mem_to_reg, link, illegal;
    logic [1:0]  pc_src, mem_read, mem_write;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    obs_t        obs;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mc_controller #(.MUL_CYCLES(c_MUL), .ALUOP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .rsgz        (rsgz),
        .rsez        (rsez),
        .tes         (tes),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .link        (link),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .illegal     (illegal),
        .state       (state)
    );

    assign obs = {fetch_req, ir_we, pc_we, pc_src, reg_write, reg_dst, alu_src,
                  mem_to_reg, link, alu_op, mem_read, mem_write, illegal, state};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare on the falling edge, then move to just after the next rising edge.
    task automatic step(input string tag, input obs_t e);
        @(negedge clk);
        check(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // ISA-level classification: kind, ALU code, immediate/dest select, access size.
    task automatic spec_row(input logic [31:0] ins, output kind_e k, output logic [3:0] aop,
                            output logic src, output logic dst, output logic [1:0] sz);
        k = K_BAD; aop = 4'd0; src = 1'b0; dst = 1'b0; sz = 2'd0;
        case (ins[31:26])
            6'h00: if (ins[5:0] == 6'h08) k = K_JR; else begin k = K_R; dst = 1'b1; end
            6'h01, 6'h04, 6'h05: k = K_BR;
            6'h06: begin k = K_BR; aop = 4'd8; end
            6'h07: begin k = K_BR; aop = 4'd7; end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h08: begin k = K_ALUI; aop = 4'd1; src = 1'b1; end
            6'h0A: begin k = K_ALUI; aop = 4'd3; src = 1'b1; end
            6'h0C: begin k = K_ALUI; aop = 4'd4; src = 1'b1; end
            6'h0D: begin k = K_ALUI; aop = 4'd5; src = 1'b1; end
            6'h0E: begin k = K_ALUI; aop = 4'd2; src = 1'b1; end
            6'h20: begin k = K_LOAD;  aop = 4'd1; src = 1'b1; sz = 2'd1; end
            6'h21: begin k = K_LOAD;  aop = 4'd1; src = 1'b1; sz = 2'd2; end
            6'h23: begin k = K_LOAD;  aop = 4'd1; src = 1'b1; sz = 2'd3; end
            6'h28: begin k = K_STORE; aop = 4'd1; src = 1'b1; sz = 2'd1; end
            6'h29: begin k = K_STORE; aop = 4'd1; src = 1'b1; sz = 2'd2; end
            6'h2B: begin k = K_STORE; aop = 4'd1; src = 1'b1; sz = 2'd3; end
`ifdef MIPS_MC_MUL_EN
            6'h1C: begin k = K_MUL; aop = 4'hB; dst = 1'b1; end
`endif
            default: k = K_BAD;
        endcase
    endtask

    function automatic logic taken(input logic [31:0] ins, input logic gz, input logic ez, input logic te);
        case (ins[31:26])
            6'h01:   return ins[16] ? (ez | gz) : (!ez && !gz);   // rs>=0 : rs<0
            6'h04:   return te;
            6'h05:   return !te;
            6'h06:   return ez | !gz;                            // rs<=0
            6'h07:   return gz & !ez;                            // rs>0
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset(input string tag);
        obs_t z;
        z = '0;
        rst_n = 1'b0;
        #1;
        check({tag, ".async"}, 32'(obs), 32'(z));
        step({tag, ".hold"}, z);
        rst_n = 1'b1;
        step({tag, ".rel"}, z);     // fetch_req only after the next edge
    endtask

    // One instruction from FETCH back to FETCH (or into TRAP, then reset).
    // abort_at >= 0 pulses reset during that MEM cycle.
    task automatic run_one(input string nm, input logic [31:0] ins, input int fwait,
                           input logic gz, input logic ez, input logic te,
                           input int mwait, input int abort_at);
        kind_e k; logic [3:0] aop; logic src, dst; logic [1:0] sz;
        obs_t e, c;
        spec_row(ins, k, aop, src, dst, sz);
        c = '0; c.alu_op = aop; c.alu_src = src; c.reg_dst = dst;

        for (int i = 0; i <= fwait; i++) begin
            instr_valid = (i == fwait);
            instr       = (i == fwait) ? ins : $urandom;
            mem_ready   = 1'($urandom);
            e = '0; e.state = S_FETCH; e.fetch_req = 1'b1; e.ir_we = (i == fwait);
            step({nm, ".fetch"}, e);
        end

        instr_valid = 1'b0;
        instr = ins; rsgz = gz; rsez = ez; tes = te;
        e = c; e.state = S_DECODE;
        case (k)
            K_BR:  begin e.pc_we = 1'b1; e.pc_src = taken(ins, gz, ez, te) ? 2'b01 : 2'b00; end
            K_J:   begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
            K_JAL: begin e.pc_we = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1; e.link = 1'b1; end
            K_JR:  begin e.pc_we = 1'b1; e.pc_src = 2'b11; end
            default: ;
        endcase
        step({nm, ".decode"}, e);

        // From here the fetch bus and flags carry garbage.
        instr = $urandom; rsgz = 1'($urandom); rsez = 1'($urandom); tes = 1'($urandom);

        case (k)
            K_R, K_ALUI, K_LOAD, K_STORE: begin
                mem_ready = 1'($urandom);
                e = c; e.state = S_EXEC;
                step({nm, ".exec"}, e);
                if (k == K_LOAD || k == K_STORE) begin
                    for (int j = 0; j <= mwait; j++) begin
                        mem_ready = (j == mwait);
                        e = c; e.state = S_MEM;
                        if (k == K_LOAD) e.mem_read = sz; else e.mem_write = sz;
                        if (j == abort_at) begin
                            mem_ready = 1'b0;
                            #1;
                            check({nm, ".mem_pre"}, 32'(obs), 32'(e));
                            do_reset({nm, ".abort"});
                            return;
                        end
                        if (k == K_STORE && j == mwait) e.pc_we = 1'b1;
                        step({nm, ".mem"}, e);
                    end
                end
                if (k != K_STORE) begin
                    mem_ready = 1'($urandom);
                    e = c; e.state = S_WB; e.reg_write = 1'b1; e.pc_we = 1'b1;
                    e.mem_to_reg = (k == K_LOAD);
                    step({nm, ".wb"}, e);
                end
            end
            K_MUL: begin
                for (int j = 0; j < c_MUL; j++) begin
                    e = c; e.state = S_MULW;
                    step({nm, ".mulw"}, e);
                end
                e = c; e.state = S_WB; e.reg_write = 1'b1; e.pc_we = 1'b1;
                step({nm, ".wb"}, e);
            end
            K_BAD: begin
                for (int j = 0; j < 3; j++) begin
                    instr_valid = 1'($urandom); mem_ready = 1'($urandom);
                    e = '0; e.state = S_TRAP; e.illegal = 1'b1;
                    step({nm, ".trap"}, e);
                end
                instr_valid = 1'b0;
                do_reset({nm, ".rst"});
            end
            default: ;
        endcase
    endtask

    logic [5:0] ops [0:19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h1C, 6'h20, 6'h21,
                               6'h23, 6'h28, 6'h29, 6'h2B};

    initial begin
        @(posedge clk);
        #1;
        do_reset("init");

        // Directed scenarios
        run_one("addi", {6'h08, 26'h0123456}, 1, 1'b0, 1'b0, 1'b0, 0, -1);
        run_one("lw",   {6'h23, 26'h0A0B0C0}, 0, 1'b0, 1'b0, 1'b0, 3, -1);
        run_one("bne0", {6'h05, 26'h0001234}, 0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_one("bne1", {6'h05, 26'h0001234}, 0, 1'b0, 1'b0, 1'b1, 0, -1);
        run_one("jal",  {6'h03, 26'h3FFFFFF}, 0, 1'b1, 1'b0, 1'b1, 0, -1);
        run_one("mul",  {6'h1C, 26'h0000002}, 0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_one("sw_abort", {6'h2B, 26'h0000010}, 0, 1'b0, 1'b0, 1'b0, 3, 1);
        run_one("bgez", {6'h01, 5'd3, 5'd1, 16'h0040}, 0, 1'b0, 1'b1, 1'b0, 0, -1);
        run_one("bltz", {6'h01, 5'd3, 5'd0, 16'h0040}, 0, 1'b0, 1'b1, 1'b0, 0, -1);
        run_one("jr",   {6'h00, 20'h12345, 6'h08}, 2, 1'b0, 1'b0, 1'b0, 0, -1);
        run_one("sb",   {6'h28, 26'h0000004}, 0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_one("undef", {6'h3F, 26'h0}, 0, 1'b0, 1'b0, 1'b0, 0, -1);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(7, 0) != 0) ins[31:26] = ops[$urandom_range(19, 0)];
            if (ins[31:26] == 6'h00 && $urandom_range(3, 0) == 0) ins[5:0] = 6'h08;
            run_one("rnd", ins, int'($urandom_range(2, 0)), 1'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(3, 0)),
                    ($urandom_range(15, 0) == 0) ? 0 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
- REQ-001 SHALL have parameter MUL_CYCLES, default 4: cycles spent in MULW (legal range 1..16).
- REQ-002 SHALL have parameter ALUOP_W, default 4: width of alu_op.
- REQ-003 SHALL have the following ports:
  - clk  in  1  sole clock, all state updates on the rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - instr  in  32  instruction word, valid while instr_valid=1.
  - instr_valid  in  1  fetch return strobe.
  - rsgz, rsez, tes  in  1 each  rs>0, rs==0, rs==rt flags, valid in DECODE.
  - mem_ready  in  1  data memory completion.
  - fetch_req  out  1  instruction fetch request.
  - ir_we, pc_we  out  1 each  IR load and PC update strobes.
  - pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
  - reg_write, reg_dst, alu_src, mem_to_reg, link  out  1 each  datapath controls.
  - alu_op  out  ALUOP_W  ALU operation.
  - mem_read, mem_write  out  2 each  00 none, 01 byte, 10 half, 11 word.
  - illegal  out  1  sticky illegal-opcode flag.
  - state  out  3  current state, for debug.

Function
- REQ-004 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, MULW, TRAP.
- REQ-005 FETCH SHALL assert fetch_req; on instr_valid=1 it SHALL pulse ir_we and go to DECODE, else hold.
- REQ-006 DECODE SHALL latch opcode/funct/rt[16] into an internal register; all later states decode from the latched copy only.
- REQ-007 DECODE routing:
  - R-type (non-jr), addi, xori, slti, andi, ori, lw/lh/lb/sw/sh/sb SHALL go to EXEC.
  - mul (011100) SHALL go to MULW.
  - Undefined opcodes SHALL go to TRAP.
- REQ-008 Branches SHALL resolve in DECODE with pc_we=1, then go to FETCH; pc_src=01 when taken, 00 otherwise.
  - BGEZ (rt[16]=1): taken on rsez|rsgz.
  - BLTZ: taken on !rsez&!rsgz.
  - BGTZ: taken on rsgz&!rsez.
  - BLEZ: taken on rsez|!rsgz.
  - BEQ: taken on tes.
  - BNE: taken on !tes.
- REQ-009 Jumps SHALL complete in DECODE with pc_we=1, then go to FETCH.
  - j: pc_src=10.
  - jal: pc_src=10 plus reg_write=1 and link=1 (writes $31).
  - jr (R-type, funct 001000): pc_src=11, reg_write=0.
- REQ-010 alu_op encodings: R 0000, addi/loads/stores 0001, xori 0010, slti 0011, andi 0100, ori 0101, bgtz 0111, blez 1000, mul 1011.
- REQ-011 alu_src=1 for immediates and memory ops; reg_dst=1 for R-type and mul.
- REQ-012 EXEC SHALL last one cycle: ALU ops go to WB, memory ops go to MEM.
- REQ-013 MEM SHALL hold mem_read (loads) or mem_write (stores) at the size code until mem_ready=1, then:
  - loads go to WB;
  - stores pulse pc_we (pc_src=00) and go to FETCH.
- REQ-014 mem_ready=1 on the first MEM cycle SHALL complete MEM in one cycle.
- REQ-015 WB SHALL assert reg_write=1 and pc_we=1 (pc_src=00) for one cycle, set mem_to_reg=1 for loads, then go to FETCH.
- REQ-016 MULW SHALL load a counter with MUL_CYCLES-1 on entry, decrement it each cycle, and go to WB in the cycle the counter reads 0.
- REQ-017 TRAP SHALL set illegal=1 and hold all strobes at 0; it SHALL be left only via reset.
- REQ-018 Outside the states named above, every strobe SHALL be 0: at most one of ir_we/pc_we is asserted per cycle, and mem_read/mem_write are never both non-zero.

Reset
- REQ-019 While rst_n=0:
  - state SHALL be FETCH;
  - counter and latched IR SHALL be 0;
  - every output SHALL be 0, including illegal and fetch_req.
- REQ-020 fetch_req SHALL rise in the first clk edge after rst_n deasserts.
- REQ-021 Reset asserted mid-MEM or mid-MULW SHALL abort immediately, with no write strobe after the reset edge.

Configuration
- REQ-022 With macro MIPS_MC_MUL_EN defined, mul SHALL be decoded per REQ-007 and REQ-016.
- REQ-023 With MIPS_MC_MUL_EN undefined, MULW and the counter SHALL be omitted and opcode 011100 SHALL go to TRAP.

Structure
- REQ-024 Package mips_ctrl_pkg SHALL hold opcode/funct constants, the state enum, the alu_op codes and the mem size codes.
- REQ-025 Opcode classification SHALL live in combinational sub-module mips_ctrl_decode; the FSM, counter and latch stay in the top module.

Verification
- REQ-026 The bench SHALL cover these directed scenarios:
  - addi with instr_valid on cycle 2 -> FETCH,FETCH,DECODE,EXEC,WB; reg_write=1, pc_we=1, alu_op=0001 in WB.
  - lw with mem_ready held 0 for 3 cycles -> mem_read=11 for 4 cycles, then WB with mem_to_reg=1.
  - BNE with tes=0, then again with tes=1 -> DECODE pc_src=01, then 00; no EXEC either time.
  - jal -> one DECODE cycle with pc_src=10, reg_write=1, link=1; next state FETCH.
  - mul with MUL_CYCLES=3 and macro defined -> exactly 3 MULW cycles, then WB with alu_op=1011; same instr with macro undefined -> TRAP, illegal=1 until rst_n=0.
  - rst_n pulsed low during the 2nd MEM cycle of sw -> mem_write=00 immediately, state=FETCH, no pc_we.
